pattern_serializer_fsm: RTL and testbench
=========================================

Name: pattern_serializer_fsm

Overview:
- Serial bit-pattern transmitter: the source end of the team's serial pattern-detection path.
- Latches a PAT_W-bit pattern on a start request and shifts it out MSB first on dataOut.
- Each bit is held for DIV_MAX clocks, so a detector on a divided clock can sample it.
- Supports back-to-back repeats with an optional zero gap; reports busy/done to the controlling logic.

Parameters:
PAT_W, 4, pattern width in bits (>=2)
DIV_MAX, 125000000, clocks per serial bit (>=2; simulation uses 4)
REPEAT_W, 4, width of repeat count input
GAP_BITS, 0, bit periods of forced 0 inserted between repeats (not after last)

Ports:
CLOCK  input  1  system clock, all logic on rising edge
Rst_n  input  1  asynchronous active-low reset
start  input  1  transmission request, level-sampled in IDLE
pattern  input  PAT_W  pattern to send, latched on accept
repeatCount  input  REPEAT_W  extra repetitions; total sends = repeatCount+1, latched on accept
dataOut  output  1  serial data, registered
bitTick  output  1  one-cycle strobe on the clock where a new bit period begins
busy  output  1  high from accept through end of last bit period
done  output  1  one-cycle pulse after final bit period

Behaviour:
- Interface decision (fixed): one clock; reset is asynchronous and active-low. Ports are CLOCK and Rst_n.
- Reset (Rst_n=0, async, any time including mid-transfer):
  - state=IDLE; dataOut=0, bitTick=0, busy=0, done=0.
  - Divider, shift register, bit counter and repeat counter cleared.
  - After release, stays in IDLE until start.
- Divider:
  - divCnt counts 0..DIV_MAX-1 only while busy.
  - Cleared on accept.
  - Period-end event when divCnt==DIV_MAX-1.
- States:
  - IDLE: dataOut=0, busy=0. If start=1 at an edge (accept):
    - latch pattern and repeatCount; load shift register; bitIdx=0, rptLeft=repeatCount.
    - Go to SHIFT. Same edge: dataOut<=pattern[PAT_W-1], busy<=1, bitTick<=1.
  - SHIFT: at each period end:
    - if bitIdx<PAT_W-1, shift; dataOut<=next bit; bitTick pulse.
    - else last bit done (PARITY if enabled):
      - rptLeft>0 and GAP_BITS>0 -> GAP, dataOut<=0.
      - rptLeft>0 and GAP_BITS==0 -> reload pattern, rptLeft-1, stay SHIFT, dataOut<=MSB.
      - rptLeft==0 -> DONE.
  - GAP: dataOut=0 for GAP_BITS periods (bitTick at each start). Then reload pattern, rptLeft-1, SHIFT.
  - DONE: entered at final period-end edge. dataOut<=0, busy<=0, done<=1 for exactly one clock, then IDLE.
- Timing:
  - busy is high for exactly (repeatCount+1)*B*DIV_MAX + repeatCount*GAP_BITS*DIV_MAX clocks, with B=PAT_W (+1 if parity).
  - done asserts the cycle busy falls.
- Boundary rules:
  - start while busy or in DONE: ignored, with no effect on latched data.
  - start held high continuously: next accept occurs on the first IDLE cycle after done, giving exactly one idle clock between transfers.
  - pattern/repeatCount changes during busy: ignored.
  - repeatCount = all ones: counter must not wrap early. Sends 2^REPEAT_W copies.
  - Unused state encodings -> IDLE with outputs cleared.

Optional Feature:
- Macro PATSER_PARITY_EN.
- When defined:
  - A PARITY state follows each pattern's last bit (before any GAP) for one bit period.
  - dataOut = even parity (XOR of latched pattern bits); bitTick pulses at its start.
  - B = PAT_W+1.
- When undefined: no PARITY state or logic; B = PAT_W.

Test Plan:
- Reset: Rst_n low mid-SHIFT, asynchronously (between edges) -> dataOut/busy/done/bitTick go 0 immediately. No activity after release until start.
- Single send (DIV_MAX=4, pattern=4'b1101, repeatCount=0, one-cycle start) -> dataOut 1,1,0,1 each held 4 clocks. busy high 16 clocks. bitTick at clocks 0,4,8,12. done pulse on clock 16.
- Repeats (pattern=1101, repeatCount=2, GAP_BITS=0):
  - dataOut 110111011101, busy 48 clocks.
  - Companion detector on same divided rate asserts on bits 4, 8, 12.
  - Repeat with GAP_BITS=2: 1101 00 1101 00 1101, busy 64 clocks.
- Start ignored: pulse start with pattern=4'b0110 at clock 6 of a 1101 send -> output unchanged.
- Held start: start held high across a 1101 send -> done, one IDLE clock, new busy. No lost or merged bits.
- Parity (PATSER_PARITY_EN, pattern=1101) -> dataOut 11011, busy 20 clocks. Pattern=1001 -> 10010.

Source files
------------

// File: rtl/pattern_serializer_fsm.sv
// pattern_serializer_fsm
// Serial bit-pattern transmitter. A PAT_W-bit pattern is latched on a start
// request and shifted out MSB first on dataOut, each bit held for DIV_MAX
// clocks. The pattern is sent repeatCount+1 times, with GAP_BITS zero bit
// periods between copies (never after the last copy).
//
// Optional build macro: PATSER_PARITY_EN
//   When defined, an even-parity bit period (XOR of the pattern) follows the
//   last data bit of every copy, ahead of any gap.
module pattern_serializer_fsm #(
    parameter int PAT_W    = 4,
    parameter int DIV_MAX  = 125000000,
    parameter int REPEAT_W = 4,
    parameter int GAP_BITS = 0
) (
    input  logic                CLOCK,
    input  logic                Rst_n,
    input  logic                start,
    input  logic [PAT_W-1:0]    pattern,
    input  logic [REPEAT_W-1:0] repeatCount,
    output logic                dataOut,
    output logic                bitTick,
    output logic                busy,
    output logic                done
);

    localparam int DIV_W = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_BITS > 0) ? GAP_W'(GAP_BITS - 1) : '0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SHIFT  = 3'd1;
    localparam logic [2:0] S_GAP    = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
`ifdef PATSER_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [2:0]          r_state;
    logic [DIV_W-1:0]    r_divCnt;
    logic [PAT_W-1:0]    r_pat;       // latched pattern, used for reload and parity
    logic [PAT_W-2:0]    r_shift;     // bits of the current copy not yet on the line
    logic [IDX_W-1:0]    r_bitIdx;
    logic [REPEAT_W-1:0] r_rptLeft;
    logic [GAP_W-1:0]    r_gapCnt;
    logic                r_dataOut;
    logic                r_bitTick;
    logic                r_busy;
    logic                r_done;

    logic w_perEnd;    // last clock of the current bit period
    logic w_copyEnd;   // last bit period of a pattern copy (data or parity) ends now
    logic w_gapEnd;    // last gap bit period ends now
    logic w_reload;    // start the next copy on this edge

    assign w_perEnd = r_busy && (r_divCnt == DIV_LAST);

`ifdef PATSER_PARITY_EN
    assign w_copyEnd = w_perEnd && (r_state == S_PARITY);
`else
    assign w_copyEnd = w_perEnd && (r_state == S_SHIFT) && (r_bitIdx == IDX_LAST);
`endif

    assign w_gapEnd = w_perEnd && (r_state == S_GAP) && (r_gapCnt == GAP_LAST);
    assign w_reload = w_copyEnd || w_gapEnd;

    // Bit-period divider: runs only while busy, restarts on accept and wraps
    // at each period end so every bit is held exactly DIV_MAX clocks.
    always_ff @(posedge CLOCK or negedge Rst_n) begin
        if (!Rst_n) begin
            r_divCnt <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_divCnt <= '0;
        end else if (r_busy) begin
            r_divCnt <= w_perEnd ? '0 : r_divCnt + 1'b1;
        end
    end

    // Transmit FSM: accept, shift bits, optional parity/gap, repeat, done pulse.
    always_ff @(posedge CLOCK or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= S_IDLE;
            r_pat     <= '0;
            r_shift   <= '0;
            r_bitIdx  <= '0;
            r_rptLeft <= '0;
            r_gapCnt  <= '0;
            r_dataOut <= 1'b0;
            r_bitTick <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_bitTick <= 1'b0;
            r_done    <= 1'b0;
            if (w_copyEnd && (r_rptLeft == '0)) begin
                // Final bit period over: busy drops and done pulses together.
                r_state   <= S_DONE;
                r_dataOut <= 1'b0;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
            end else if (w_copyEnd && (GAP_BITS > 0)) begin
                r_state   <= S_GAP;
                r_gapCnt  <= '0;
                r_dataOut <= 1'b0;
                r_bitTick <= 1'b1;
            end else if (w_reload) begin
                // Next copy starts straight from the latched pattern; the
                // count only decrements here, so all-ones cannot wrap early.
                r_state   <= S_SHIFT;
                r_shift   <= r_pat[PAT_W-2:0];
                r_bitIdx  <= '0;
                r_rptLeft <= r_rptLeft - 1'b1;
                r_dataOut <= r_pat[PAT_W-1];
                r_bitTick <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_dataOut <= 1'b0;
                        r_busy    <= 1'b0;
                        if (start) begin
                            r_state   <= S_SHIFT;
                            r_pat     <= pattern;
                            r_shift   <= pattern[PAT_W-2:0];
                            r_bitIdx  <= '0;
                            r_rptLeft <= repeatCount;
                            r_gapCnt  <= '0;
                            r_dataOut <= pattern[PAT_W-1];
                            r_busy    <= 1'b1;
                            r_bitTick <= 1'b1;
                        end
                    end
                    S_SHIFT: begin
                        if (w_perEnd) begin
                            if (r_bitIdx != IDX_LAST) begin
                                r_dataOut <= r_shift[PAT_W-2];
                                r_shift   <= r_shift << 1;
                                r_bitIdx  <= r_bitIdx + 1'b1;
                                r_bitTick <= 1'b1;
                            end
`ifdef PATSER_PARITY_EN
                            else begin
                                r_state   <= S_PARITY;
                                r_dataOut <= ^r_pat;
                                r_bitTick <= 1'b1;
                            end
`endif
                        end
                    end
`ifdef PATSER_PARITY_EN
                    S_PARITY: begin
                        // Parity period end is handled by w_copyEnd above.
                        r_busy <= 1'b1;
                    end
`endif
                    S_GAP: begin
                        if (w_perEnd) begin
                            r_gapCnt  <= r_gapCnt + 1'b1;
                            r_bitTick <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        // start is deliberately not looked at here.
                        r_state   <= S_IDLE;
                        r_dataOut <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_dataOut <= 1'b0;
                        r_busy    <= 1'b0;
                        r_bitTick <= 1'b0;
                        r_done    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dataOut = r_dataOut;
    assign bitTick = r_bitTick;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_pattern_serializer_fsm.sv
// Bench for pattern_serializer_fsm: two instances (GAP_BITS=0 and 2) share
// stimulus; a per-cycle waveform model plus literal run summaries check them.
module tb_pattern_serializer_fsm;

    localparam int DIV = 4;
`ifdef PATSER_PARITY_EN
    localparam int PB = 1;
    localparam logic [127:0] E_SINGLE = 128'b11011;
    localparam int L_SINGLE = 5,  BZ_SINGLE = 20;
    localparam logic [127:0] E_R0 = 128'b110111101111011;
    localparam int L_R0 = 15,     BZ_R0 = 60;
    localparam logic [127:0] E_R2 = 128'b1101100110110011011;
    localparam int L_R2 = 19,     BZ_R2 = 76;
    localparam logic [127:0] E_HELD = 128'b1101111011;
    localparam int L_HELD = 10,   BZ_HELD = 40;
    localparam logic [127:0] E_1001 = 128'b10010;
    localparam int L_1001 = 5,    BZ_1001 = 20;
    localparam int BZ_ALL0 = 320, BZ_ALL2 = 440;
`else
    localparam int PB = 0;
    localparam logic [127:0] E_SINGLE = 128'b1101;
    localparam int L_SINGLE = 4,  BZ_SINGLE = 16;
    localparam logic [127:0] E_R0 = 128'b110111011101;
    localparam int L_R0 = 12,     BZ_R0 = 48;
    localparam logic [127:0] E_R2 = 128'b1101001101001101;
    localparam int L_R2 = 16,     BZ_R2 = 64;
    localparam logic [127:0] E_HELD = 128'b11011101;
    localparam int L_HELD = 8,    BZ_HELD = 32;
    localparam logic [127:0] E_1001 = 128'b1001;
    localparam int L_1001 = 4,    BZ_1001 = 16;
    localparam int BZ_ALL0 = 256, BZ_ALL2 = 376;
`endif

    logic       CLOCK = 1'b0;
    logic       Rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] pattern = 4'd0;
    logic [3:0] repeatCount = 4'd0;
    logic do0, tk0, bz0, dn0, do1, tk1, bz1, dn1;
    logic [1:0] w_do, w_tk, w_bz, w_dn;

    assign w_do = {do1, do0};
    assign w_tk = {tk1, tk0};
    assign w_bz = {bz1, bz0};
    assign w_dn = {dn1, dn0};

    pattern_serializer_fsm #(.PAT_W(4), .DIV_MAX(DIV), .REPEAT_W(4), .GAP_BITS(0)) u_g0 (
        .CLOCK(CLOCK), .Rst_n(Rst_n), .start(start), .pattern(pattern),
        .repeatCount(repeatCount), .dataOut(do0), .bitTick(tk0), .busy(bz0), .done(dn0));

    pattern_serializer_fsm #(.PAT_W(4), .DIV_MAX(DIV), .REPEAT_W(4), .GAP_BITS(2)) u_g2 (
        .CLOCK(CLOCK), .Rst_n(Rst_n), .start(start), .pattern(pattern),
        .repeatCount(repeatCount), .dataOut(do1), .bitTick(tk1), .busy(bz1), .done(dn1));

    always #5 CLOCK = ~CLOCK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Model: each accepted request becomes a list of bit periods; the
    // expected outputs follow from the elapsed clock count within the run.
    bit           m_act[2];
    bit           m_dn[2];
    int           m_k[2];
    int           m_len[2];
    bit           m_seq[2][256];
    logic [127:0] cap[2];
    int           capN[2], busyN[2], doneN[2], lowRun[2], lastGap[2];
    bit           prevBz[2];

    initial begin
        forever begin
            @(negedge CLOCK);
            for (int d = 0; d < 2; d++) begin
                logic ebz, edo, etk, edn;
                int   gap;
                gap = (d == 1) ? 2 : 0;
                if (!Rst_n) begin
                    m_act[d] = 1'b0;
                    m_dn[d]  = 1'b0;
                    m_k[d]   = 0;
                end
                ebz = m_act[d];
                edo = m_act[d] ? m_seq[d][m_k[d] / DIV] : 1'b0;
                etk = m_act[d] && ((m_k[d] % DIV) == 0);
                edn = m_dn[d];
                chk($sformatf("dut%0d busy t=%0t", d, $time),    w_bz[d], ebz);
                chk($sformatf("dut%0d dataOut t=%0t", d, $time), w_do[d], edo);
                chk($sformatf("dut%0d bitTick t=%0t", d, $time), w_tk[d], etk);
                chk($sformatf("dut%0d done t=%0t", d, $time),    w_dn[d], edn);
                // run statistics for the literal checks
                if (w_bz[d]) busyN[d]++;
                if (w_dn[d]) doneN[d]++;
                if (w_tk[d]) begin
                    cap[d] = {cap[d][126:0], w_do[d]};
                    capN[d]++;
                end
                if (w_bz[d] && !prevBz[d]) lastGap[d] = lowRun[d];
                lowRun[d] = w_bz[d] ? 0 : lowRun[d] + 1;
                prevBz[d] = w_bz[d];
                // advance the model to the state after the coming rising edge
                if (Rst_n) begin
                    if (m_act[d]) begin
                        m_k[d]++;
                        if (m_k[d] == m_len[d] * DIV) begin
                            m_act[d] = 1'b0;
                            m_dn[d]  = 1'b1;
                        end
                    end else if (m_dn[d]) begin
                        m_dn[d] = 1'b0;
                    end else if (start) begin
                        m_len[d] = 0;
                        for (int r = 0; r <= int'(repeatCount); r++) begin
                            for (int i = 3; i >= 0; i--) begin
                                m_seq[d][m_len[d]] = pattern[i];
                                m_len[d]++;
                            end
                            if (PB == 1) begin
                                m_seq[d][m_len[d]] = ^pattern;
                                m_len[d]++;
                            end
                            if (r < int'(repeatCount)) begin
                                for (int g = 0; g < gap; g++) begin
                                    m_seq[d][m_len[d]] = 1'b0;
                                    m_len[d]++;
                                end
                            end
                        end
                        m_act[d] = 1'b1;
                        m_k[d]   = 0;
                    end
                end
            end
        end
    end

    task automatic tick1();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic clr();
        for (int d = 0; d < 2; d++) begin
            cap[d] = '0; capN[d] = 0; busyN[d] = 0; doneN[d] = 0;
        end
    endtask

    // One-cycle start request; inputs are scrambled afterwards to show that
    // changes during busy have no effect.
    task automatic send(input logic [3:0] p, input logic [3:0] rc);
        start = 1'b1; pattern = p; repeatCount = rc;
        tick1();
        start = 1'b0; pattern = ~p; repeatCount = ~rc;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while ((w_bz != 2'b00 || w_dn != 2'b00) && n < maxc) begin
            tick1();
            n++;
        end
        if (w_bz != 2'b00 || w_dn != 2'b00) begin
            checks++;
            errors++;
            $display("FAIL wait_idle timeout: busy=%b done=%b, expected 00", w_bz, w_dn);
        end
        tick1();
    endtask

    task automatic check_run(input string nm, input int d, input logic [127:0] ebits,
                             input int elen, input int ebusy, input int edone);
        chk({nm, " bits"},   cap[d],   ebits);
        chk({nm, " nbits"},  capN[d],  elen);
        chk({nm, " busy"},   busyN[d], ebusy);
        chk({nm, " dones"},  doneN[d], edone);
    endtask

    initial begin
        int dc, n;
        tick1(); tick1();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset dut%0d outputs", d),
                {w_do[d], w_tk[d], w_bz[d], w_dn[d]}, 4'b0000);
        end
        Rst_n = 1'b1;
        repeat (3) tick1();
        chk("idle after release", {w_bz, w_dn}, 4'b0000);

        // single send
        clr(); send(4'b1101, 4'd0); wait_idle(200);
        check_run("single g0", 0, E_SINGLE, L_SINGLE, BZ_SINGLE, 1);
        check_run("single g2", 1, E_SINGLE, L_SINGLE, BZ_SINGLE, 1);

        // repeats
        clr(); send(4'b1101, 4'd2); wait_idle(300);
        check_run("repeat g0", 0, E_R0, L_R0, BZ_R0, 1);
        check_run("repeat g2", 1, E_R2, L_R2, BZ_R2, 1);

        // start pulsed mid-transfer with a different pattern
        clr(); send(4'b1101, 4'd0);
        repeat (5) tick1();
        start = 1'b1; pattern = 4'b0110; repeatCount = 4'd3;
        tick1();
        start = 1'b0;
        wait_idle(200);
        check_run("ignored g0", 0, E_SINGLE, L_SINGLE, BZ_SINGLE, 1);

        // start held high across two transfers
        clr();
        start = 1'b1; pattern = 4'b1101; repeatCount = 4'd0;
        dc = 0; n = 0;
        while (dc < 2 && n < 200) begin
            tick1();
            n++;
            if (dn0) dc++;
        end
        start = 1'b0;
        chk("held done seen", dc, 2);
        wait_idle(200);
        check_run("held g0", 0, E_HELD, L_HELD, BZ_HELD, 2);
        chk("held gap g0", lastGap[0], 2);
        chk("held gap g2", lastGap[1], 2);

        // parity/content of a different pattern
        clr(); send(4'b1001, 4'd0); wait_idle(200);
        check_run("p1001 g0", 0, E_1001, L_1001, BZ_1001, 1);

        // repeatCount all ones: 16 copies, no early wrap
        clr(); send(4'b1001, 4'hF); wait_idle(1000);
        chk("allones g0 busy", busyN[0], BZ_ALL0);
        chk("allones g2 busy", busyN[1], BZ_ALL2);
        chk("allones g0 dones", doneN[0], 1);

        // asynchronous reset in the middle of SHIFT
        clr(); send(4'b1101, 4'd1);
        repeat (4) tick1();
        #1 Rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("async reset dut%0d outputs", d),
                {w_do[d], w_tk[d], w_bz[d], w_dn[d]}, 4'b0000);
        end
        tick1(); tick1();
        Rst_n = 1'b1;
        clr();
        repeat (8) tick1();
        chk("no activity after reset", busyN[0] + busyN[1] + capN[0] + capN[1], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
